// File: rtl/multi_frame_buffer.sv
// multi_frame_buffer: N-buffer (2..4) frame store between a frame writer and
// a scanning reader. With NUM_BUFS>=3 the writer never stalls and stale
// pending frames are dropped. NUM_BUFS=2 is a handshaked double buffer.
// Optional: define MFB_DROP_COUNT_EN to build the saturating drop counter.
module multi_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 600,
  parameter int NUM_BUFS   = 3,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BUF_IDX_W  = $clog2(NUM_BUFS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_done,
  output logic                  o_wr_ready,
  input  logic                  i_rd_acquire,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_new,
  output logic                  o_pending,
  output logic [15:0]           o_drop_count
);

  if (NUM_BUFS < 2 || NUM_BUFS > 4) begin : g_bad_num_bufs
    $error("multi_frame_buffer: NUM_BUFS must be 2..4");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [NUM_BUFS][DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [BUF_IDX_W-1:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d, pend_idx_q, pend_idx_d;
  logic                  pend_valid_q, pend_valid_d, wr_ready_q, wr_ready_d, rd_new_q;
  logic                  acq, done, drop;

  // Acquire only means something when a frame is pending; done only when the writer owns a buffer.
  assign acq  = i_rd_acquire & pend_valid_q;
  assign done = i_wr_done & wr_ready_q;

  if (NUM_BUFS >= 3) begin : g_triple
    logic [BUF_IDX_W-1:0] free_idx;
    logic                 found;
    // Next buffer ownership: acquire first, then publish; writer moves to the lowest free buffer.
    always_comb begin
      rd_idx_d     = acq ? pend_idx_q : rd_idx_q;
      wr_idx_d     = wr_idx_q;
      pend_idx_d   = pend_idx_q;
      pend_valid_d = pend_valid_q & ~acq;
      wr_ready_d   = 1'b1;
      drop         = 1'b0;
      free_idx     = '0;
      found        = 1'b0;
      for (int b = 0; b < NUM_BUFS; b++) begin
        if (!found && BUF_IDX_W'(b) != rd_idx_d && BUF_IDX_W'(b) != wr_idx_q) begin
          free_idx = BUF_IDX_W'(b);
          found    = 1'b1;
        end
      end
      if (done) begin
        pend_idx_d   = wr_idx_q;
        pend_valid_d = 1'b1;
        wr_idx_d     = free_idx;
        // An unacquired pending frame is overwritten by the newer one.
        drop         = pend_valid_q & ~acq;
      end
    end
  end else begin : g_double
    // Double buffer: publish stalls the writer until the reader swaps buffers.
    always_comb begin
      rd_idx_d     = rd_idx_q;
      wr_idx_d     = wr_idx_q;
      pend_idx_d   = pend_idx_q;
      pend_valid_d = pend_valid_q;
      wr_ready_d   = wr_ready_q;
      drop         = 1'b0;
      if (acq) begin
        rd_idx_d     = pend_idx_q;
        wr_idx_d     = rd_idx_q;
        pend_valid_d = 1'b0;
        wr_ready_d   = 1'b1;
      end else if (done) begin
        pend_idx_d   = wr_idx_q;
        pend_valid_d = 1'b1;
        wr_ready_d   = 1'b0;
      end
    end
  end

  // Buffer ownership state and the acquire-switched pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_idx_q     <= '0;
      wr_idx_q     <= BUF_IDX_W'(1);
      pend_idx_q   <= '0;
      pend_valid_q <= 1'b0;
      wr_ready_q   <= 1'b1;
      rd_new_q     <= 1'b0;
    end else begin
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      pend_idx_q   <= pend_idx_d;
      pend_valid_q <= pend_valid_d;
      wr_ready_q   <= wr_ready_d;
      rd_new_q     <= acq;
    end
  end

  // Frame storage write port; out-of-range addresses are dropped. Not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && wr_ready_q && ({1'b0, i_wr_addr} < DEPTH_L))
      mem_q[wr_idx_q][i_wr_addr] <= i_wr_data;
  end

  // Registered read port: buffer select and address sampled on the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      rd_data_q <= '0;
    else if ({1'b0, i_rd_addr} < DEPTH_L)
      rd_data_q <= mem_q[rd_idx_q][i_rd_addr];
  end

`ifdef MFB_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;
  // Saturating count of frames overwritten before the reader took them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign o_drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop  = drop;
  assign o_drop_count = 16'd0;
`endif

  assign o_wr_ready = wr_ready_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_new   = rd_new_q;
  assign o_pending  = pend_valid_q;

endmodule

// File: tb/tb_multi_frame_buffer.sv
// Bench for multi_frame_buffer: a triple-buffer (index 0) and a double-buffer
// (index 1) instance share stimulus; a frame-level model predicts both.
module tb_multi_frame_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 12;
  localparam int AW = 4;
`ifdef MFB_DROP_COUNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic we, done, acq;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  logic rdy [2];
  logic rnew [2];
  logic pend [2];
  logic [DW-1:0] rdata [2];
  logic [15:0] dcnt [2];

  always #5 clk = ~clk;

  multi_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BUFS(3)) u_mfb3 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
    .i_wr_done(done), .o_wr_ready(rdy[0]), .i_rd_acquire(acq), .i_rd_addr(ra),
    .o_rd_data(rdata[0]), .o_rd_new(rnew[0]), .o_pending(pend[0]), .o_drop_count(dcnt[0]));

  multi_frame_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BUFS(2)) u_mfb2 (
    .i_clk(clk), .i_rst(rst), .i_wr_en(we), .i_wr_addr(wa), .i_wr_data(wd),
    .i_wr_done(done), .o_wr_ready(rdy[1]), .i_rd_acquire(acq), .i_rd_addr(ra),
    .o_rd_data(rdata[1]), .o_rd_new(rnew[1]), .o_pending(pend[1]), .o_drop_count(dcnt[1]));

  // Model: per instance three frames (0 = being written, 1 = pending, 2 = shown)
  // with a valid mask; unwritten words hold stale data and are not checked.
  logic [DW-1:0] fd [2][3][DEPTH];
  bit            fv [2][3][DEPTH];
  bit            mpend [2], mrdy [2], mnew [2], erv [2];
  int            mdrop [2];
  logic [DW-1:0] erd [2];
  int checks, errors;

  task automatic chk(string name, int m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  task automatic copy_frame(int m, int src, int dst);
    for (int i = 0; i < DEPTH; i++) begin
      fd[m][dst][i] = fd[m][src][i];
      fv[m][dst][i] = fv[m][src][i];
    end
  endtask

  task automatic clear_frame(int m, int s);
    for (int i = 0; i < DEPTH; i++) fv[m][s][i] = 1'b0;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mpend[m] = 0; mrdy[m] = 1; mnew[m] = 0; mdrop[m] = 0;
      erv[m] = 1; erd[m] = '0;
      for (int s = 0; s < 3; s++) clear_frame(m, s);
    end
  endtask

  // One clock edge of the frame-level rules, using pre-edge model state.
  task automatic model_step();
    bit a, d;
    int ia, iw;
    ia = int'(ra);
    iw = int'(wa);
    for (int m = 0; m < 2; m++) begin
      erv[m] = (ia < DEPTH) && fv[m][2][ia];
      erd[m] = erv[m] ? fd[m][2][ia] : '0;
      if (we && mrdy[m] && iw < DEPTH) begin
        fd[m][0][iw] = wd;
        fv[m][0][iw] = 1'b1;
      end
      a = acq && mpend[m];
      d = done && mrdy[m];
      mnew[m] = a;
      if (m == 0) begin
        if (a) begin copy_frame(m, 1, 2); mpend[m] = 0; end
        if (d) begin
          if (mpend[m]) mdrop[m]++;
          copy_frame(m, 0, 1); clear_frame(m, 0); mpend[m] = 1;
        end
      end else begin
        if (a) begin
          copy_frame(m, 1, 2); clear_frame(m, 0); mpend[m] = 0; mrdy[m] = 1;
        end else if (d) begin
          copy_frame(m, 0, 1); mpend[m] = 1; mrdy[m] = 0;
        end
      end
    end
  endtask

  // Compare every model-visible output of both instances.
  task automatic compare();
    int ed;
    for (int m = 0; m < 2; m++) begin
      ed = (DROP_EN != 0 && m == 0) ? ((mdrop[m] > 65535) ? 65535 : mdrop[m]) : 0;
      chk("wr_ready", m, 32'(rdy[m]), 32'(mrdy[m]));
      chk("pending", m, 32'(pend[m]), 32'(mpend[m]));
      chk("rd_new", m, 32'(rnew[m]), 32'(mnew[m]));
      chk("drop_count", m, 32'(dcnt[m]), 32'(ed));
      if (erv[m]) chk("rd_data", m, 32'(rdata[m]), 32'(erd[m]));
    end
  endtask

  task automatic cyc(bit we_, logic [AW-1:0] wa_, logic [DW-1:0] wd_, bit done_, bit acq_,
                     logic [AW-1:0] ra_);
    we = we_; wa = wa_; wd = wd_; done = done_; acq = acq_; ra = ra_;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    we = 0; wa = '0; wd = '0; done = 0; acq = 0; ra = 4'd5;
    rst = 1'b1;
    model_reset();
    #12;
    compare();
    chk("reset_rd_data", 0, 32'(rdata[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 4'd5, 8'h00, 0, 0, 4'd5);

    // First frame through both buffers
    cyc(1, 4'd0, 8'h11, 0, 0, 4'd0);
    cyc(1, 4'd1, 8'h22, 0, 0, 4'd0);
    cyc(1, 4'd2, 8'h33, 0, 0, 4'd0);
    cyc(0, 4'd0, 8'h00, 1, 0, 4'd0);
    chk("lit_pending_after_done", 0, 32'(pend[0]), 32'h1);
    chk("lit_stall_after_done", 1, 32'(rdy[1]), 32'h0);
    cyc(1, 4'd0, 8'hAA, 0, 0, 4'd0);
    cyc(0, 4'd0, 8'h00, 0, 1, 4'd0);
    chk("lit_rd_new", 0, 32'(rnew[0]), 32'h1);
    chk("lit_rd_new", 1, 32'(rnew[1]), 32'h1);
    chk("lit_ready_after_acq", 1, 32'(rdy[1]), 32'h1);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd0);
    chk("lit_rd0", 0, 32'(rdata[0]), 32'h11);
    chk("lit_rd0", 1, 32'(rdata[1]), 32'h11);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd1);
    chk("lit_rd1", 0, 32'(rdata[0]), 32'h22);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd2);
    chk("lit_rd2", 0, 32'(rdata[0]), 32'h33);
    chk("lit_rd2", 1, 32'(rdata[1]), 32'h33);

    // Three frames published with no acquire
    cyc(1, 4'd0, 8'hA1, 0, 0, 4'd0); cyc(0, 4'd0, 8'h00, 1, 0, 4'd0);
    cyc(1, 4'd0, 8'hB2, 0, 0, 4'd0); cyc(0, 4'd0, 8'h00, 1, 0, 4'd0);
    cyc(1, 4'd0, 8'hC3, 0, 0, 4'd0); cyc(0, 4'd0, 8'h00, 1, 0, 4'd0);
    chk("lit_drop_two", 0, 32'(dcnt[0]), (DROP_EN != 0) ? 32'd2 : 32'd0);
    chk("lit_ready_never_low", 0, 32'(rdy[0]), 32'h1);
    cyc(0, 4'd0, 8'h00, 0, 1, 4'd0);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd0);
    chk("lit_newest_frame", 0, 32'(rdata[0]), 32'hC3);
    chk("lit_prestall_frame", 1, 32'(rdata[1]), 32'hA1);

    // Same-cycle acquire and done with a frame pending
    cyc(1, 4'd1, 8'h44, 0, 0, 4'd1); cyc(0, 4'd0, 8'h00, 1, 0, 4'd1);
    cyc(1, 4'd1, 8'h55, 0, 0, 4'd1);
    cyc(0, 4'd0, 8'h00, 1, 1, 4'd1);
    chk("lit_simul_rd_new", 0, 32'(rnew[0]), 32'h1);
    chk("lit_simul_pending", 0, 32'(pend[0]), 32'h1);
    chk("lit_simul_nodrop", 0, 32'(dcnt[0]), (DROP_EN != 0) ? 32'd2 : 32'd0);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd1);
    chk("lit_simul_older", 0, 32'(rdata[0]), 32'h44);
    chk("lit_simul_older", 1, 32'(rdata[1]), 32'h44);
    cyc(0, 4'd0, 8'h00, 0, 1, 4'd1);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd1);
    chk("lit_simul_newer", 0, 32'(rdata[0]), 32'h55);

    // Randomized traffic, including out-of-range writes
    for (int n = 0; n < 3000; n++)
      cyc(($urandom % 4) != 0, AW'($urandom_range(0, 15)), DW'($urandom),
          ($urandom % 8) == 0, ($urandom % 6) == 0, AW'($urandom_range(0, DEPTH-1)));

    // Asynchronous reset in the middle of a frame
    cyc(1, 4'd3, 8'h77, 0, 0, 4'd3);
    cyc(0, 4'd0, 8'h00, 1, 0, 4'd3);
    cyc(1, 4'd4, 8'h78, 0, 0, 4'd3);
    we = 0; done = 0; acq = 0;
    #2 rst = 1'b1;
    #1 model_reset();
    compare();
    chk("lit_async_pending", 0, 32'(pend[0]), 32'h0);
    chk("lit_async_rd_data", 1, 32'(rdata[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 4'd0, 8'h00, 0, 1, 4'd3);
    chk("lit_acq_noop", 0, 32'(rnew[0]), 32'h0);
    chk("lit_acq_noop", 1, 32'(rnew[1]), 32'h0);
    cyc(0, 4'd0, 8'h00, 0, 0, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
